// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer with an on-demand side/pedestrian phase.
// A per-state down-counter paces the phase FSM on each tick_en strobe.
module traffic_light_ctrl #(
    parameter int MAIN_TICKS = 5,
    parameter int SIDE_TICKS = 4,
    parameter int YEL_TICKS  = 2,
    parameter int RED_TICKS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic       ped_ack,
    output logic [2:0] phase,
    output logic [2:0] timer
);
    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        RED_A  = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        RED_B  = 3'd5
    } state_t;

    localparam logic [2:0] MAIN_LD = 3'(MAIN_TICKS - 1);
    localparam logic [2:0] SIDE_LD = 3'(SIDE_TICKS - 1);
    localparam logic [2:0] YEL_LD  = 3'(YEL_TICKS - 1);
    localparam logic [2:0] RED_LD  = 3'(RED_TICKS - 1);

    state_t     state_q, state_d;
    logic [2:0] timer_q, timer_d;
    logic       ped_pend_q, ped_pend_d;
    logic       side_pend_q, side_pend_d;
    logic       ped_ack_q, ped_ack_d;
    logic       advance;
    logic       enter_side;

    function automatic logic [2:0] load_of(input state_t s);
        case (s)
            MAIN_G:         return MAIN_LD;
            MAIN_Y, SIDE_Y: return YEL_LD;
            RED_A, RED_B:   return RED_LD;
            SIDE_G:         return SIDE_LD;
            default:        return MAIN_LD;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        advance = 1'b0;
        if (tick_en) begin
            if (timer_q != 3'd0) timer_d = timer_q - 3'd1;
            else                 advance = 1'b1;
        end
        // MAIN_G parks at timer 0 until a request is pending.
        case (state_q)
            MAIN_G:  if (advance && (ped_pend_q || side_pend_q)) state_d = MAIN_Y;
            MAIN_Y:  if (advance) state_d = RED_A;
            RED_A:   if (advance) state_d = SIDE_G;
            SIDE_G:  if (advance) state_d = SIDE_Y;
            SIDE_Y:  if (advance) state_d = RED_B;
            RED_B:   if (advance) state_d = MAIN_G;
            default: state_d = MAIN_G;
        endcase
        if (state_d != state_q) timer_d = load_of(state_d);

        // Entering SIDE_G serves everything, including same-cycle requests.
        enter_side  = (state_d == SIDE_G) && (state_q != SIDE_G);
        ped_pend_d  = enter_side ? 1'b0 : (ped_pend_q | ped_req);
        side_pend_d = enter_side ? 1'b0 : (side_pend_q | side_req);
        ped_ack_d   = ped_req & ~ped_pend_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MAIN_G;
            timer_q     <= MAIN_LD;
            ped_pend_q  <= 1'b0;
            side_pend_q <= 1'b0;
            ped_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ped_pend_q  <= ped_pend_d;
            side_pend_q <= side_pend_d;
            ped_ack_q   <= ped_ack_d;
        end
    end

    always_comb begin
        main_light = 3'b100;
        side_light = 3'b100;
        ped_walk   = 1'b0;
        case (state_q)
            MAIN_G: main_light = 3'b001;
            MAIN_Y: main_light = 3'b010;
            SIDE_G: begin
                side_light = 3'b001;
                ped_walk   = 1'b1;
            end
            SIDE_Y: side_light = 3'b010;
            default: ;
        endcase
    end

    assign phase   = state_q;
    assign timer   = timer_q;
    assign ped_ack = ped_ack_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: expected per-cycle outputs are
// queued from the phase/duration table, then popped and compared each cycle.
module tb_traffic_light_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_en = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       ped_walk;
    logic       ped_ack;
    logic [2:0] phase;
    logic [2:0] timer;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [2:0] ph;
        logic [2:0] tm;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       walk;
        logic       ack;
    } vec_t;

    vec_t exp_q[$];

    traffic_light_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .ped_walk   (ped_walk),
        .ped_ack    (ped_ack),
        .phase      (phase),
        .timer      (timer)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int dur(input int s);
        case (s)
            0: return 5;
            1: return 2;
            2: return 1;
            3: return 4;
            4: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic vec_t observe();
        vec_t v;
        v.ph = phase; v.tm = timer; v.ml = main_light;
        v.sl = side_light; v.walk = ped_walk; v.ack = ped_ack;
        return v;
    endfunction

    function automatic string fmt(input vec_t v);
        return $sformatf("ph=%0d tm=%0d ml=%b sl=%b w=%b a=%b",
                         v.ph, v.tm, v.ml, v.sl, v.walk, v.ack);
    endfunction

    task automatic push_cycle(input int ph, input int tm);
        vec_t v;
        v.ph = 3'(ph); v.tm = 3'(tm);
        v.ml = 3'b100; v.sl = 3'b100; v.walk = 1'b0; v.ack = 1'b0;
        case (ph)
            0: v.ml = 3'b001;
            1: v.ml = 3'b010;
            3: begin v.sl = 3'b001; v.walk = 1'b1; end
            4: v.sl = 3'b010;
            default: ;
        endcase
        exp_q.push_back(v);
    endtask

    // One complete round MAIN_G(min)..RED_B, each tick stretched to 'scale' cycles.
    task automatic push_round(input int scale);
        for (int s = 0; s < 6; s++)
            for (int k = 0; k < dur(s) * scale; k++)
                push_cycle(s, dur(s) - 1 - k / scale);
    endtask

    task automatic push_idle(input int n, input int scale);
        for (int k = 0; k < n; k++)
            push_cycle(0, (k / scale >= 4) ? 0 : 4 - k / scale);
    endtask

    task automatic set_ack(input int idx);
        vec_t v;
        v = exp_q[idx];
        v.ack = 1'b1;
        exp_q[idx] = v;
    endtask

    task automatic drive(input logic t, input logic s, input logic p);
        tick_en = t; side_req = s; ped_req = p;
    endtask

    // Leaves the bench at posedge+1 with reset just released: cycle 0 begins.
    task automatic do_reset();
        drive(0, 0, 0);
        reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        n_vec += 6;
        if (phase !== 3'd0)        begin n_miss++; $display("FAIL reset_phase got %0d want 0", phase); end
        if (timer !== 3'd4)        begin n_miss++; $display("FAIL reset_timer got %0d want 4", timer); end
        if (main_light !== 3'b001) begin n_miss++; $display("FAIL reset_main got %b want 001", main_light); end
        if (side_light !== 3'b100) begin n_miss++; $display("FAIL reset_side got %b want 100", side_light); end
        if (ped_walk !== 1'b0)     begin n_miss++; $display("FAIL reset_walk got %b want 0", ped_walk); end
        if (ped_ack !== 1'b0)      begin n_miss++; $display("FAIL reset_ack got %b want 0", ped_ack); end
        $display("reset: outputs checked with no clock edge");
    endtask

    task automatic test_idle();
        vec_t obs, e;
        do_reset();
        push_idle(12, 1);
        for (int c = 0; exp_q.size() > 0; c++) begin
            drive(1, 0, 0);
            #1;
            obs = observe(); e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_miss++;
                $display("FAIL idle cyc %0d got %s want %s", c, fmt(obs), fmt(e));
            end
            @(posedge clk); #1;
        end
        $display("idle: 12 cycles, no requests");
    endtask

    task automatic test_ped_pulse();
        vec_t obs, e;
        do_reset();
        push_round(1);
        push_idle(6, 1);
        set_ack(3);
        for (int c = 0; exp_q.size() > 0; c++) begin
            drive(1, 0, c == 2);
            #1;
            obs = observe(); e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_miss++;
                $display("FAIL ped_pulse cyc %0d got %s want %s", c, fmt(obs), fmt(e));
            end
            if (c == 8) begin
                n_vec++;
                if (dut.ped_pend_q !== 1'b0) begin
                    n_miss++;
                    $display("FAIL ped_pend_after_entry got %b want 0", dut.ped_pend_q);
                end
            end
            @(posedge clk); #1;
        end
        $display("ped_pulse: one pedestrian round");
    endtask

    task automatic test_slow_tick();
        vec_t obs, e;
        do_reset();
        push_round(4);
        push_idle(4, 4);
        for (int c = 0; exp_q.size() > 0; c++) begin
            drive((c % 4) == 3, 1, 0);
            #1;
            obs = observe(); e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_miss++;
                $display("FAIL slow_tick cyc %0d got %s want %s", c, fmt(obs), fmt(e));
            end
            @(posedge clk); #1;
        end
        $display("slow_tick: tick every 4th cycle, side_req held");
    endtask

    task automatic test_ped_during_side();
        vec_t obs, e;
        do_reset();
        push_round(1);
        push_round(1);
        push_idle(6, 1);
        set_ack(3);
        set_ack(10);
        for (int c = 0; exp_q.size() > 0; c++) begin
            drive(1, 0, (c == 2) || (c == 9));
            #1;
            obs = observe(); e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_miss++;
                $display("FAIL ped_during_side cyc %0d got %s want %s", c, fmt(obs), fmt(e));
            end
            @(posedge clk); #1;
        end
        $display("ped_during_side: second round after 5 main ticks");
    endtask

    task automatic test_reset_mid_side();
        vec_t obs, e;
        do_reset();
        push_round(1);
        while (exp_q.size() > 10) void'(exp_q.pop_back());
        set_ack(3);
        for (int c = 0; exp_q.size() > 0; c++) begin
            drive(1, 0, (c == 2) || (c == 9));
            #1;
            obs = observe(); e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_miss++;
                $display("FAIL mid_side_pre cyc %0d got %s want %s", c, fmt(obs), fmt(e));
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0);
        #2 reset = 1'b0;
        #1;
        n_vec += 6;
        if (phase !== 3'd0)        begin n_miss++; $display("FAIL mid_reset_phase got %0d want 0", phase); end
        if (timer !== 3'd4)        begin n_miss++; $display("FAIL mid_reset_timer got %0d want 4", timer); end
        if (main_light !== 3'b001) begin n_miss++; $display("FAIL mid_reset_main got %b want 001", main_light); end
        if (side_light !== 3'b100) begin n_miss++; $display("FAIL mid_reset_side got %b want 100", side_light); end
        if (ped_walk !== 1'b0)     begin n_miss++; $display("FAIL mid_reset_walk got %b want 0", ped_walk); end
        if (ped_ack !== 1'b0)      begin n_miss++; $display("FAIL mid_reset_ack got %b want 0", ped_ack); end
        @(posedge clk); #1;
        reset = 1'b1;
        push_idle(10, 1);
        for (int c = 0; exp_q.size() > 0; c++) begin
            drive(1, 0, 0);
            #1;
            obs = observe(); e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin
                n_miss++;
                $display("FAIL mid_side_post cyc %0d got %s want %s", c, fmt(obs), fmt(e));
            end
            @(posedge clk); #1;
        end
        $display("reset_mid_side: async reset in SIDE_G, pending request dropped");
    endtask

    task automatic test_back_to_back();
        vec_t obs, e;
        do_reset();
        for (int r = 0; r < 4; r++) push_round(1);
        push_idle(6, 1);
        set_ack(1);
        set_ack(9);
        set_ack(24);
        set_ack(39);
        for (int c = 0; exp_q.size() > 0; c++) begin
            drive(1, 0, c < 40);
            #1;
            obs = observe(); e = exp_q.pop_front(); n_vec += 2;
            if (obs !== e) begin
                n_miss++;
                $display("FAIL held_ped cyc %0d got %s want %s", c, fmt(obs), fmt(e));
            end
            if (main_light !== 3'b100 && side_light !== 3'b100) begin
                n_miss++;
                $display("FAIL safety cyc %0d main=%b side=%b, want at least one red", c, main_light, side_light);
            end
            @(posedge clk); #1;
        end
        $display("back_to_back: ped_req held 40 cycles");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_ped_pulse();
        test_slow_tick();
        test_ped_during_side();
        test_reset_mid_side();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
